mem_port_arbiter: RTL and testbench

Single-outstanding arbiter sharing one external memory port between the instruction-cache refill engine (requester I, read-only bursts) and the data-cache refill/writeback engine (requester D, read or write bursts). It sits below both caches, above the bus bridge. A grant is locked from request acceptance until the final response of that transaction. Fairness between I and D is round-robin.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 73 +++++++
 rtl/mem_port_arbiter_rr_arb2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_WRESP = 3'd4
  } state_t;

  // Requester identifiers; bit position in the request vector matches the ID
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Two-way round-robin pick: a lone requester wins outright, a tie goes to
  // whoever did not win last time.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    if (req[REQ_I] && req[REQ_D]) begin
      pick = ~last_grant;
    end else if (req[REQ_D]) begin
      pick = REQ_D;
    end else begin
      pick = REQ_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundled cache-side and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);

  // Instruction-cache refill port
  logic              inst_rd_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [LEN_W-1:0]  inst_len_i;
  logic              inst_accept_o;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_data_o;
  logic              inst_last_o;
  logic              inst_error_o;

  // Data-cache refill/writeback port
  logic                data_rd_i;
  logic                data_wr_i;
  logic [ADDR_W-1:0]   data_addr_i;
  logic [LEN_W-1:0]    data_len_i;
  logic                data_accept_o;
  logic [DATA_W-1:0]   data_wdata_i;
  logic [DATA_W/8-1:0] data_wstrb_i;
  logic                data_wvalid_i;
  logic                data_wready_o;
  logic                data_valid_o;
  logic [DATA_W-1:0]   data_data_o;
  logic                data_last_o;
  logic                data_error_o;

  // Downstream memory port
  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [LEN_W-1:0]    mem_len_o;
  logic                mem_accept_i;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_wstrb_o;
  logic                mem_wvalid_o;
  logic                mem_wready_i;
  logic                mem_rvalid_i;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                mem_rlast_i;
  logic                mem_err_i;
  logic                mem_bvalid_i;

  // Arbiter view
  modport slave (
    input  inst_rd_i, inst_addr_i, inst_len_i,
    output inst_accept_o, inst_valid_o, inst_data_o, inst_last_o, inst_error_o,
    input  data_rd_i, data_wr_i, data_addr_i, data_len_i,
    input  data_wdata_i, data_wstrb_i, data_wvalid_i,
    output data_accept_o, data_wready_o, data_valid_o, data_data_o, data_last_o, data_error_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_len_o, mem_wdata_o, mem_wstrb_o, mem_wvalid_o,
    input  mem_accept_i, mem_wready_i, mem_rvalid_i, mem_rdata_i, mem_rlast_i, mem_err_i,
    input  mem_bvalid_i
  );

  // Environment view (caches above, bus bridge below)
  modport master (
    output inst_rd_i, inst_addr_i, inst_len_i,
    input  inst_accept_o, inst_valid_o, inst_data_o, inst_last_o, inst_error_o,
    output data_rd_i, data_wr_i, data_addr_i, data_len_i,
    output data_wdata_i, data_wstrb_i, data_wvalid_i,
    input  data_accept_o, data_wready_o, data_valid_o, data_data_o, data_last_o, data_error_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_len_o, mem_wdata_o, mem_wstrb_o, mem_wvalid_o,
    output mem_accept_i, mem_wready_i, mem_rvalid_i, mem_rdata_i, mem_rlast_i, mem_err_i,
    output mem_bvalid_i
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - two-way round-robin pick with last-grant memory
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic       gnt_id_o,
  output logic       last_grant_o
);

  logic r_last_grant;

  // Remember who won the most recently accepted transaction; D at reset so I wins the first tie
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_grant <= REQ_D;
    end else if (upd_i) begin
      r_last_grant <= upd_id_i;
    end
  end

  // Pick the winner from the live request lines
  always_comb begin
    gnt_id_o = rr_pick(req_i, r_last_grant);
  end

  assign last_grant_o = r_last_grant;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding I/D cache arbiter for one external memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  mem_port_arbiter_if.slave bus
);

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_mem_req;

  logic [1:0] w_req;
  logic       w_any;
  logic       w_gnt_id;
  logic       w_last_grant;
  logic       w_accept;
  logic       w_whs;
  logic       w_rd_i_sel;
  logic       w_rd_d_sel;
  logic       w_bresp;

  assign w_req[REQ_I] = bus.inst_rd_i;
  assign w_req[REQ_D] = bus.data_rd_i | bus.data_wr_i;
  assign w_any        = |w_req;

  assign w_accept   = (r_state == ST_REQ) && bus.mem_accept_i;
  assign w_whs      = (r_state == ST_WR) && bus.data_wvalid_i && bus.mem_wready_i;
  assign w_rd_i_sel = (r_state == ST_RD) && (r_owner == REQ_I) && bus.mem_rvalid_i;
  assign w_rd_d_sel = (r_state == ST_RD) && (r_owner == REQ_D) && bus.mem_rvalid_i;
  assign w_bresp    = (r_state == ST_WRESP) && bus.mem_bvalid_i;

  // The last-grant pointer only moves once the memory side has taken the request
  mem_port_arbiter_rr_arb2 u_rr (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_i        (w_req),
    .upd_i        (w_accept),
    .upd_id_i     (r_owner),
    .gnt_id_o     (w_gnt_id),
    .last_grant_o (w_last_grant)
  );

  // Transaction FSM: latch the winner's request, present it, then track the burst to completion
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= REQ_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner   <= w_gnt_id;
            r_we      <= (w_gnt_id == REQ_D) && bus.data_wr_i;
            r_addr    <= (w_gnt_id == REQ_D) ? bus.data_addr_i : bus.inst_addr_i;
            r_len     <= (w_gnt_id == REQ_D) ? bus.data_len_i  : bus.inst_len_i;
            r_mem_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_accept_i) begin
            r_mem_req <= 1'b0;
            r_cnt     <= r_len;
            r_state   <= r_we ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          // rlast alone ends the burst; the counter is only a diagnostic here
          if (bus.mem_rvalid_i) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end
            if (bus.mem_rlast_i) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WR: begin
          if (w_whs) begin
            if (r_cnt == '0) begin
              r_state <= ST_WRESP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        ST_WRESP: begin
          if (bus.mem_bvalid_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Downstream request fields come straight from the latched registers
  assign bus.mem_req_o  = r_mem_req;
  assign bus.mem_we_o   = r_we;
  assign bus.mem_addr_o = r_addr;
  assign bus.mem_len_o  = r_len;

  // Write beats pass through only while a write burst owns the port
  always_comb begin
    bus.mem_wvalid_o  = 1'b0;
    bus.mem_wdata_o   = '0;
    bus.mem_wstrb_o   = '0;
    bus.data_wready_o = 1'b0;
    if (r_state == ST_WR) begin
      bus.mem_wvalid_o  = bus.data_wvalid_i;
      bus.mem_wdata_o   = bus.data_wdata_i;
      bus.mem_wstrb_o   = bus.data_wstrb_i;
      bus.data_wready_o = bus.mem_wready_i;
    end
  end

  // Request acceptance pulses go to the owner in the same cycle as the memory accept
  assign bus.inst_accept_o = w_accept && (r_owner == REQ_I);
  assign bus.data_accept_o = w_accept && (r_owner == REQ_D);

  // Read beats are steered to the owner; the other side sees nothing
  always_comb begin
    bus.inst_valid_o = w_rd_i_sel;
    bus.inst_data_o  = w_rd_i_sel ? bus.mem_rdata_i : '0;
    bus.inst_last_o  = w_rd_i_sel && bus.mem_rlast_i;
    bus.inst_error_o = w_rd_i_sel && bus.mem_err_i;
  end

  // D responses are either read beats or the single write-response pulse
  always_comb begin
    bus.data_valid_o = w_rd_d_sel || w_bresp;
    bus.data_data_o  = w_rd_d_sel ? bus.mem_rdata_i : '0;
    bus.data_last_o  = (w_rd_d_sel && bus.mem_rlast_i) || w_bresp;
    bus.data_error_o = (w_rd_d_sel || w_bresp) && bus.mem_err_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_rd_i     = 0; bus.inst_addr_i = '0; bus.inst_len_i = '0;
    bus.data_rd_i     = 0; bus.data_wr_i   = 0;  bus.data_addr_i = '0; bus.data_len_i = '0;
    bus.data_wdata_i  = '0; bus.data_wstrb_i = '0; bus.data_wvalid_i = 0;
    bus.mem_accept_i  = 0; bus.mem_wready_i = 0; bus.mem_rvalid_i = 0;
    bus.mem_rdata_i   = '0; bus.mem_rlast_i = 0; bus.mem_err_i = 0; bus.mem_bvalid_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    tick();
    tick();
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_accepts", {bus.inst_accept_o, bus.data_accept_o}, 0);
    check("rst_valids", {bus.inst_valid_o, bus.data_valid_o, bus.mem_wvalid_o}, 0);
    rstn = 1;
    tick();
  endtask

  // In REQ: verify presented fields, stall accept for 'stall' cycles, then accept
  task automatic grant_accept(input logic own_d, input logic [31:0] addr,
                              input logic [7:0] len, input logic we, input int stall);
    for (int i = 0; i <= stall; i++) begin
      check("req_valid", bus.mem_req_o, 1);
      check("req_addr", bus.mem_addr_o, addr);
      check("req_len", bus.mem_len_o, len);
      check("req_we", bus.mem_we_o, we);
      check("req_no_accept", {bus.inst_accept_o, bus.data_accept_o}, 0);
      if (i < stall) tick();
    end
    bus.mem_accept_i = 1;
    #1;
    check("accept_pulse", {bus.inst_accept_o, bus.data_accept_o}, own_d ? 2'b01 : 2'b10);
    tick();
    bus.mem_accept_i = 0;
    if (own_d) begin
      bus.data_rd_i = 0;
      bus.data_wr_i = 0;
    end else begin
      bus.inst_rd_i = 0;
    end
    #1;
    check("req_dropped", bus.mem_req_o, 0);
  endtask

  // Drive nbeats read beats; rlast asserted when b == last_idx
  task automatic read_beats(input logic to_d, input int nbeats, input int last_idx,
                            input int err_beat, input logic [31:0] seed);
    for (int b = 0; b < nbeats; b++) begin
      bus.mem_rvalid_i = 1;
      bus.mem_rdata_i  = seed + b;
      bus.mem_rlast_i  = (b == last_idx);
      bus.mem_err_i    = (b == err_beat);
      #1;
      if (to_d) begin
        check("d_valid", bus.data_valid_o, 1);
        check("d_data", bus.data_data_o, seed + b);
        check("d_last", bus.data_last_o, b == last_idx);
        check("d_err", bus.data_error_o, b == err_beat);
        check("i_quiet", bus.inst_valid_o, 0);
      end else begin
        check("i_valid", bus.inst_valid_o, 1);
        check("i_data", bus.inst_data_o, seed + b);
        check("i_last", bus.inst_last_o, b == last_idx);
        check("i_err", bus.inst_error_o, b == err_beat);
        check("d_quiet", bus.data_valid_o, 0);
      end
      tick();
    end
    bus.mem_rvalid_i = 0;
    bus.mem_rlast_i  = 0;
    bus.mem_err_i    = 0;
  endtask

  initial begin
    int hs;
    n_tests = 0;
    n_fail  = 0;
    rstn    = 0;
    clear_inputs();

    // I-only read, len=7
    do_reset();
    bus.inst_rd_i = 1; bus.inst_addr_i = 32'h8000_0000; bus.inst_len_i = 8'd7;
    #1;
    check("no_comb_req", bus.mem_req_o, 0);
    tick();
    grant_accept(0, 32'h8000_0000, 8'd7, 0, 0);
    read_beats(0, 8, 7, -1, 32'h1000);
    check("i_done_idle", bus.mem_req_o, 0);

    // Simultaneous requests after reset alternate I, D, I
    do_reset();
    bus.inst_rd_i = 1; bus.inst_addr_i = 32'h100; bus.inst_len_i = 8'd1;
    bus.data_rd_i = 1; bus.data_addr_i = 32'h200; bus.data_len_i = 8'd1;
    tick();
    grant_accept(0, 32'h100, 8'd1, 0, 0);
    read_beats(0, 2, 1, -1, 32'h2000);
    check("bubble", bus.mem_req_o, 0);
    tick();
    grant_accept(1, 32'h200, 8'd1, 0, 0);
    read_beats(1, 2, 1, -1, 32'h3000);
    bus.inst_rd_i = 1; bus.inst_addr_i = 32'h110; bus.inst_len_i = 8'd0;
    bus.data_rd_i = 1; bus.data_addr_i = 32'h210; bus.data_len_i = 8'd0;
    tick();
    grant_accept(0, 32'h110, 8'd0, 0, 0);
    read_beats(0, 1, 0, -1, 32'h4000);
    tick();
    grant_accept(1, 32'h210, 8'd0, 0, 0);
    read_beats(1, 1, 0, -1, 32'h5000);

    // D write len=3, accept stalled 5 cycles, wready toggling
    do_reset();
    bus.data_wr_i = 1; bus.data_addr_i = 32'h3000; bus.data_len_i = 8'd3;
    tick();
    grant_accept(1, 32'h3000, 8'd3, 1, 5);
    hs = 0;
    for (int cyc = 0; cyc < 16 && hs < 4; cyc++) begin
      bus.mem_wready_i  = (cyc % 2 == 0);
      bus.data_wvalid_i = 1;
      bus.data_wdata_i  = 32'hA0 + hs;
      bus.data_wstrb_i  = 4'hF;
      #1;
      check("wready_mirror", bus.data_wready_o, cyc % 2 == 0);
      check("mem_wvalid", bus.mem_wvalid_o, 1);
      check("mem_wdata", bus.mem_wdata_o, 32'hA0 + hs);
      check("mem_wstrb", bus.mem_wstrb_o, 4'hF);
      check("w_no_valid", bus.data_valid_o, 0);
      tick();
      if (cyc % 2 == 0) hs++;
    end
    bus.data_wvalid_i = 0;
    bus.mem_wready_i  = 1;
    #1;
    check("wresp_no_wready", bus.data_wready_o, 0);
    check("wresp_wait", bus.data_valid_o, 0);
    tick();
    bus.mem_bvalid_i = 1;
    #1;
    check("bresp_valid", bus.data_valid_o, 1);
    check("bresp_last", bus.data_last_o, 1);
    check("bresp_err", bus.data_error_o, 0);
    check("bresp_i_quiet", bus.inst_valid_o, 0);
    tick();
    bus.mem_bvalid_i = 0;
    bus.mem_wready_i = 0;
    #1;
    check("bresp_once", bus.data_valid_o, 0);

    // I read with error on the second beat
    do_reset();
    bus.inst_rd_i = 1; bus.inst_addr_i = 32'h5000; bus.inst_len_i = 8'd3;
    tick();
    grant_accept(0, 32'h5000, 8'd3, 0, 0);
    read_beats(0, 4, 3, 1, 32'h6000);
    check("err_done_idle", bus.mem_req_o, 0);

    // Reset during the third beat of a D read
    do_reset();
    bus.data_rd_i = 1; bus.data_addr_i = 32'h7000; bus.data_len_i = 8'd7;
    tick();
    grant_accept(1, 32'h7000, 8'd7, 0, 0);
    read_beats(1, 2, 7, -1, 32'h7700);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h7702;
    #1;
    check("beat3_valid", bus.data_valid_o, 1);
    rstn = 0;
    #1;
    check("async_rst_valid", bus.data_valid_o, 0);
    check("async_rst_data", bus.data_data_o, 0);
    check("async_rst_req", bus.mem_req_o, 0);
    tick();
    rstn = 1;
    tick();
    bus.mem_rvalid_i = 1; bus.mem_rlast_i = 1;
    #1;
    check("stray_d", bus.data_valid_o, 0);
    check("stray_i", bus.inst_valid_o, 0);
    tick();
    bus.mem_rvalid_i = 0; bus.mem_rlast_i = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
